// File: rtl/ebreak_halt_ctrl_pkg.sv
// Shared NPC definitions used by the ebreak halt sequencer: halt state encoding,
// the ebreak opcode and the default watchdog exit code.
package npc_pkg;

  typedef enum logic [1:0] {
    HS_RUN    = 2'd0,
    HS_DRAIN  = 2'd1,
    HS_NOTIFY = 2'd2,
    HS_HALTED = 2'd3
  } halt_state_e;

  localparam logic [31:0] EBREAK_INSN   = 32'h0010_0073;
  localparam logic [31:0] WDOG_CODE_DEF = 32'h0000_DEAD;

  // Counter width able to hold 0..n; never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/ebreak_halt_ctrl_if.sv
// Commit-side inputs and halt-record handshake between the core, the halt
// sequencer and the DPI ebreak wrapper.
interface ebreak_halt_ctrl_if #(
  parameter int unsigned XLEN = 32
);
  logic            commit_valid;
  logic            commit_ebreak;
  logic [XLEN-1:0] commit_pc;
  logic [XLEN-1:0] a0_val;
  logic            lsu_idle;
  logic            fetch_stall;
  logic            notify_valid;
  logic            notify_ready;
  logic [XLEN-1:0] notify_code;
  logic [XLEN-1:0] notify_pc;
  logic            notify_wdog;
  logic            halted;

  // Core / wrapper side.
  modport master (
    output commit_valid, commit_ebreak, commit_pc, a0_val, lsu_idle, notify_ready,
    input  fetch_stall, notify_valid, notify_code, notify_pc, notify_wdog, halted
  );

  // Halt sequencer side.
  modport slave (
    input  commit_valid, commit_ebreak, commit_pc, a0_val, lsu_idle, notify_ready,
    output fetch_stall, notify_valid, notify_code, notify_pc, notify_wdog, halted
  );
endinterface

// File: rtl/ebreak_halt_ctrl_watchdog.sv
// No-commit watchdog: saturating counter cleared by any commit, frozen when
// disabled, pulsing expire on the cycle that would complete WDOG_CYC idle cycles.
module halt_watchdog
  import npc_pkg::*;
#(
  parameter int unsigned WDOG_CYC = 4096
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic expire
);
  localparam int unsigned CW = cnt_w(WDOG_CYC);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (en) begin
      if (clr)
        cnt <= '0;
      else if (cnt != CW'(WDOG_CYC))
        cnt <= cnt + CW'(1);
    end
  end

  // WDOG_CYC == 0 disables the watchdog entirely.
  assign expire = (WDOG_CYC != 0) && en && !clr && (cnt == CW'(WDOG_CYC - 1));

endmodule

// File: rtl/ebreak_halt_ctrl.sv
// Halt sequencer for a committed ebreak (or watchdog expiry): freeze fetch,
// drain the LSU, hand code/PC to the DPI wrapper, then stay halted until reset.
module ebreak_halt_ctrl
  import npc_pkg::*;
#(
  parameter int unsigned     XLEN      = 32,
  parameter int unsigned     DRAIN_CYC = 2,
  parameter int unsigned     WDOG_CYC  = 4096,
  parameter logic [XLEN-1:0] WDOG_CODE = XLEN'(WDOG_CODE_DEF)
) (
  input  logic               clk,
  input  logic               rst,
  ebreak_halt_ctrl_if.slave  hif
);
  localparam int unsigned DW = cnt_w(DRAIN_CYC);

  halt_state_e     st;
  logic [DW-1:0]   dcnt;
  logic [XLEN-1:0] last_pc;
  logic [XLEN-1:0] cap_code;
  logic [XLEN-1:0] cap_pc;
  logic            cap_wdog;
  logic            stall_q;
  logic            valid_q;
  logic            halted_q;
  logic            ebrk;
  logic            wd_exp;
  logic            drain_done;

  assign ebrk = hif.commit_valid & hif.commit_ebreak;

  halt_watchdog #(.WDOG_CYC(WDOG_CYC)) u_wdog (
    .clk    (clk),
    .rst    (rst),
    .en     (st == HS_RUN),
    .clr    (hif.commit_valid),
    .expire (wd_exp)
  );

  // Drain finishes on the cycle the idle streak would reach DRAIN_CYC.
  always_comb begin
    drain_done = 1'b0;
    if (DRAIN_CYC == 0)
      drain_done = 1'b1;
    else
      drain_done = hif.lsu_idle && (dcnt == DW'(DRAIN_CYC - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st       <= HS_RUN;
      dcnt     <= '0;
      last_pc  <= '0;
      cap_code <= '0;
      cap_pc   <= '0;
      cap_wdog <= 1'b0;
      stall_q  <= 1'b0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      case (st)
        HS_RUN: begin
          if (hif.commit_valid)
            last_pc <= hif.commit_pc;
          // A commit also clears the watchdog, so ebreak takes precedence.
          if (ebrk) begin
            cap_code <= hif.a0_val;
            cap_pc   <= hif.commit_pc;
            cap_wdog <= 1'b0;
            st       <= HS_DRAIN;
            stall_q  <= 1'b1;
            dcnt     <= '0;
          end else if (wd_exp) begin
            cap_code <= WDOG_CODE;
            cap_pc   <= last_pc;
            cap_wdog <= 1'b1;
            st       <= HS_DRAIN;
            stall_q  <= 1'b1;
            dcnt     <= '0;
          end
        end
        HS_DRAIN: begin
          if (drain_done) begin
            st      <= HS_NOTIFY;
            valid_q <= 1'b1;
            dcnt    <= '0;
          end else begin
            dcnt <= hif.lsu_idle ? dcnt + DW'(1) : '0;
          end
        end
        HS_NOTIFY: begin
          if (hif.notify_ready) begin
            st       <= HS_HALTED;
            valid_q  <= 1'b0;
            halted_q <= 1'b1;
          end
        end
        HS_HALTED: ;
        default: st <= HS_RUN;
      endcase
    end
  end

  assign hif.fetch_stall  = stall_q;
  assign hif.notify_valid = valid_q;
  assign hif.halted       = halted_q;
  assign hif.notify_code  = cap_code;
  assign hif.notify_pc    = cap_pc;
  assign hif.notify_wdog  = cap_wdog;

endmodule
